memy_req_ctrl: RTL and testbench

- Request controller directly upstream of the Y-memory dual-port RAM.
- Accepts two independent request channels (A, B) from the CPU datapath using valid/ready handshakes.
- Maps channel A onto RAM port x and channel B onto RAM port y.
- Resolves same-address hazards, range-checks addresses, and returns exactly one response per accepted request.

---
 rtl/memy_req_ctrl_if.sv | 37 +++
 rtl/memy_req_ctrl.sv | 127 ++++++++++++
 tb/tb_memy_req_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/memy_req_ctrl_if.sv
// Request/response channels A and B between the CPU datapath and the
// Y-memory request controller.
interface memy_req_ctrl_if #(
    parameter int unsigned W = 16
);
    logic         a_valid;
    logic         a_ready;
    logic         a_we;
    logic [W-1:0] a_addr;
    logic [W-1:0] a_wdata;
    logic         a_rsp_valid;
    logic         a_rsp_err;
    logic [W-1:0] a_rsp_rdata;

    logic         b_valid;
    logic         b_ready;
    logic         b_we;
    logic [W-1:0] b_addr;
    logic [W-1:0] b_wdata;
    logic         b_rsp_valid;
    logic         b_rsp_err;
    logic [W-1:0] b_rsp_rdata;

    modport master (
        output a_valid, a_we, a_addr, a_wdata,
        input  a_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata,
        output b_valid, b_we, b_addr, b_wdata,
        input  b_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata
    );

    modport slave (
        input  a_valid, a_we, a_addr, a_wdata,
        output a_ready, a_rsp_valid, a_rsp_err, a_rsp_rdata,
        input  b_valid, b_we, b_addr, b_wdata,
        output b_ready, b_rsp_valid, b_rsp_err, b_rsp_rdata
    );
endinterface

// File: rtl/memy_req_ctrl.sv
// Y-memory request controller: maps channel A to RAM port x and B to port y,
// defers B by one cycle on same-address hazards, range-checks addresses.
module memy_req_ctrl #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned CW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    memy_req_ctrl_if.slave req,
    output logic [W-1:0]  ram_addr_x,
    output logic [W-1:0]  ram_data_x,
    output logic          ram_we_x,
    input  logic [W-1:0]  ram_q_x,
    output logic [W-1:0]  ram_addr_y,
    output logic [W-1:0]  ram_data_y,
    output logic          ram_we_y,
    input  logic [W-1:0]  ram_q_y,
    output logic [CW-1:0] conflict_cnt
);
    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam logic [W:0] DEPTH_W = (W+1)'(DEPTH);

    state_t       state;
    state_t       state_nxt;
    logic         held_we;
    logic [W-1:0] held_addr;
    logic [W-1:0] held_wdata;

    logic a_acc, b_acc, a_in, b_in, conflict, hold_issue;
    logic a_rv_q, a_err_q, a_rd_q;
    logic b_rv_q, b_err_q, b_rd_q;

    assign a_in = {1'b0, req.a_addr} < DEPTH_W;
    assign b_in = {1'b0, req.b_addr} < DEPTH_W;

    always_comb begin
        state_nxt   = state;
        req.a_ready = 1'b0;
        req.b_ready = 1'b0;
        ram_addr_x  = '0;
        ram_data_x  = '0;
        ram_we_x    = 1'b0;
        ram_addr_y  = '0;
        ram_data_y  = '0;
        ram_we_y    = 1'b0;
        a_acc       = 1'b0;
        b_acc       = 1'b0;
        conflict    = 1'b0;
        hold_issue  = 1'b0;
        // Gating with rst_n keeps RAM strobes and ready low during reset even in HOLD
        if (rst_n) begin
            case (state)
                ST_RUN: begin
                    req.a_ready = 1'b1;
                    req.b_ready = 1'b1;
                    a_acc       = req.a_valid;
                    b_acc       = req.b_valid;
                    conflict    = a_acc && b_acc && a_in && b_in &&
                                  (req.a_addr == req.b_addr) && (req.a_we || req.b_we);
                    if (a_acc && a_in) begin
                        ram_addr_x = req.a_addr;
                        ram_data_x = req.a_wdata;
                        ram_we_x   = req.a_we;
                    end
                    if (b_acc && b_in && !conflict) begin
                        ram_addr_y = req.b_addr;
                        ram_data_y = req.b_wdata;
                        ram_we_y   = req.b_we;
                    end
                    if (conflict) state_nxt = ST_HOLD;
                end
                ST_HOLD: begin
                    hold_issue = 1'b1;
                    ram_addr_y = held_addr;
                    ram_data_y = held_wdata;
                    ram_we_y   = held_we;
                    state_nxt  = ST_RUN;
                end
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_RUN;
            held_we      <= 1'b0;
            held_addr    <= '0;
            held_wdata   <= '0;
            conflict_cnt <= '0;
            a_rv_q       <= 1'b0;
            a_err_q      <= 1'b0;
            a_rd_q       <= 1'b0;
            b_rv_q       <= 1'b0;
            b_err_q      <= 1'b0;
            b_rd_q       <= 1'b0;
        end else begin
            state <= state_nxt;
            if (conflict) begin
                held_we    <= req.b_we;
                held_addr  <= req.b_addr;
                held_wdata <= req.b_wdata;
                if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + CW'(1);
            end
            a_rv_q  <= a_acc;
            a_err_q <= a_acc && !a_in;
            a_rd_q  <= a_acc && a_in && !req.a_we;
            // A deferred B answers from the HOLD cycle, not its accept cycle
            b_rv_q  <= (b_acc && !conflict) || hold_issue;
            b_err_q <= b_acc && !b_in;
            b_rd_q  <= (b_acc && b_in && !req.b_we && !conflict) || (hold_issue && !held_we);
        end
    end

    assign req.a_rsp_valid = a_rv_q;
    assign req.a_rsp_err   = a_err_q;
    assign req.a_rsp_rdata = a_rd_q ? ram_q_x : '0;
    assign req.b_rsp_valid = b_rv_q;
    assign req.b_rsp_err   = b_err_q;
    assign req.b_rsp_rdata = b_rd_q ? ram_q_y : '0;

endmodule

// File: tb/tb_memy_req_ctrl.sv
// Randomized bench for memy_req_ctrl: a word-array memory model with
// "A before B" ordering predicts ready, RAM strobes and per-channel responses.
module tb_memy_req_ctrl;
    localparam int unsigned W = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned CNT_MAX = 15;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  ram_addr_x, ram_data_x, ram_q_x;
    logic [W-1:0]  ram_addr_y, ram_data_y, ram_q_y;
    logic          ram_we_x, ram_we_y;
    logic [CW-1:0] conflict_cnt;

    memy_req_ctrl_if #(.W(W)) bus ();

    memy_req_ctrl #(.W(W), .DEPTH(256), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (bus),
        .ram_addr_x   (ram_addr_x),
        .ram_data_x   (ram_data_x),
        .ram_we_x     (ram_we_x),
        .ram_q_x      (ram_q_x),
        .ram_addr_y   (ram_addr_y),
        .ram_data_y   (ram_data_y),
        .ram_we_y     (ram_we_y),
        .ram_q_y      (ram_q_y),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM with registered read, standing in for the real Y memory
    logic [W-1:0] ram_mem [256] = '{default: '0};
    always @(posedge clk) begin
        if (ram_we_x) ram_mem[ram_addr_x[7:0]] <= ram_data_x;
        if (ram_we_y) ram_mem[ram_addr_y[7:0]] <= ram_data_y;
        ram_q_x <= ram_mem[ram_addr_x[7:0]];
        ram_q_y <= ram_mem[ram_addr_y[7:0]];
    end

    // Reference model state
    logic [W-1:0] ref_mem [256] = '{default: '0};
    bit           bubble;
    bit           pend_we;
    logic [W-1:0] pend_addr, pend_wdata;
    int unsigned  m_cnt;
    bit           e_av [4], e_aerr [4], e_bv [4], e_berr [4];
    logic [W-1:0] e_ard [4], e_brd [4];
    int unsigned  it;

    int n_checks;
    int n_fail;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (step %0d)", tag, got, exp, it);
        end
    endtask

    task automatic step(input bit rst,
                        input bit av, input bit awe, input logic [W-1:0] aaddr, input logic [W-1:0] awdata,
                        input bit bv, input bit bwe, input logic [W-1:0] baddr, input logic [W-1:0] bwdata);
        int unsigned cur, n1;
        bit exp_rdy, exp_wex, exp_wey, a_in, b_in, conf;
        @(negedge clk);
        rst_n       = !rst;
        bus.a_valid = av;  bus.a_we = awe; bus.a_addr = aaddr; bus.a_wdata = awdata;
        bus.b_valid = bv;  bus.b_we = bwe; bus.b_addr = baddr; bus.b_wdata = bwdata;
        #1;
        cur = it % 4;
        n1  = (it + 1) % 4;

        check_eq("a_rsp_valid", 32'(bus.a_rsp_valid), 32'(e_av[cur]));
        check_eq("a_rsp_err",   32'(bus.a_rsp_err),   32'(e_aerr[cur]));
        check_eq("a_rsp_rdata", 32'(bus.a_rsp_rdata), 32'(e_ard[cur]));
        check_eq("b_rsp_valid", 32'(bus.b_rsp_valid), 32'(e_bv[cur]));
        check_eq("b_rsp_err",   32'(bus.b_rsp_err),   32'(e_berr[cur]));
        check_eq("b_rsp_rdata", 32'(bus.b_rsp_rdata), 32'(e_brd[cur]));
        check_eq("conflict_cnt", 32'(conflict_cnt), m_cnt);
        e_av[cur] = 0; e_aerr[cur] = 0; e_ard[cur] = '0;
        e_bv[cur] = 0; e_berr[cur] = 0; e_brd[cur] = '0;

        exp_wex = 0;
        exp_wey = 0;
        if (rst) begin
            exp_rdy = 0;
            bubble  = 0;
            m_cnt   = 0;
            check_eq("rst_ram_addr_x", 32'(ram_addr_x), 0);
            check_eq("rst_ram_data_x", 32'(ram_data_x), 0);
            check_eq("rst_ram_addr_y", 32'(ram_addr_y), 0);
            check_eq("rst_ram_data_y", 32'(ram_data_y), 0);
        end else if (bubble) begin
            // Deferred B takes effect now, after the A that beat it
            exp_rdy  = 0;
            exp_wey  = pend_we;
            e_bv[n1] = 1;
            if (pend_we) ref_mem[pend_addr[7:0]] = pend_wdata;
            else         e_brd[n1] = ref_mem[pend_addr[7:0]];
            bubble = 0;
        end else begin
            exp_rdy = 1;
            a_in = aaddr < 16'd256;
            b_in = baddr < 16'd256;
            conf = av && bv && a_in && b_in && (aaddr == baddr) && (awe || bwe);
            if (av) begin
                e_av[n1] = 1;
                if (!a_in) e_aerr[n1] = 1;
                else if (awe) begin
                    ref_mem[aaddr[7:0]] = awdata;
                    exp_wex = 1;
                end else e_ard[n1] = ref_mem[aaddr[7:0]];
            end
            if (bv) begin
                if (conf) begin
                    pend_we = bwe; pend_addr = baddr; pend_wdata = bwdata;
                    bubble  = 1;
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    e_bv[n1] = 1;
                    if (!b_in) e_berr[n1] = 1;
                    else if (bwe) begin
                        ref_mem[baddr[7:0]] = bwdata;
                        exp_wey = 1;
                    end else e_brd[n1] = ref_mem[baddr[7:0]];
                end
            end
        end
        check_eq("a_ready",  32'(bus.a_ready), 32'(exp_rdy));
        check_eq("b_ready",  32'(bus.b_ready), 32'(exp_rdy));
        check_eq("ram_we_x", 32'(ram_we_x), 32'(exp_wex));
        check_eq("ram_we_y", 32'(ram_we_y), 32'(exp_wey));
        it++;
    endtask

    function automatic logic [W-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return W'($urandom_range(256, 65535));
        return W'($urandom_range(0, 7));
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        it       = 0;
        bubble   = 0;
        m_cnt    = 0;
        rst_n    = 1'b0;
        bus.a_valid = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
        bus.b_valid = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            e_av[i] = 0; e_aerr[i] = 0; e_ard[i] = '0;
            e_bv[i] = 0; e_berr[i] = 0; e_brd[i] = '0;
        end

        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 16'd4, 16'hFFFF, 1, 1, 16'd4, 16'hFFFF);
        // Write then read back on A
        step(0, 1, 1, 16'd5, 16'h1234, 0, 0, 0, 0);
        step(0, 1, 0, 16'd5, 16'h0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Write/write hazard: B's data survives
        step(0, 1, 1, 16'd7, 16'hAAAA, 1, 1, 16'd7, 16'hBBBB);
        step(0, 1, 0, 16'd7, 16'h0, 1, 0, 16'd7, 16'h0);
        step(0, 1, 0, 16'd7, 16'h0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // A write / B read hazard: B sees A's data two cycles later
        step(0, 1, 1, 16'd3, 16'h0F0F, 1, 0, 16'd3, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Read/read same address: no hold
        step(0, 1, 1, 16'd9, 16'h5555, 0, 0, 0, 0);
        step(0, 1, 0, 16'd9, 16'h0, 1, 0, 16'd9, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Out-of-range B read
        step(0, 0, 0, 0, 0, 1, 0, 16'd300, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Reset during HOLD drops the held B write
        step(0, 1, 1, 16'd20, 16'h1111, 1, 1, 16'd20, 16'h2222);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 16'd20, 16'h0, 1, 0, 16'd20, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int unsigned k = 0; k < 3000; k++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), W'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), W'($urandom));
        end
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
